// File: rtl/cbus_pkg.sv
// Common cache-bus types shared by the cache ports, the arbiter and the memory side.
package cbus_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;
   typedef logic [2:0]  msize_t;
   typedef logic [3:0]  mlen_t;

   localparam msize_t MSIZE1 = 3'd0;
   localparam msize_t MSIZE2 = 3'd1;
   localparam msize_t MSIZE4 = 3'd2;
   localparam msize_t MSIZE8 = 3'd3;

   // Burst length is encoded as beats-1.
   localparam mlen_t MLEN1  = 4'd0;
   localparam mlen_t MLEN2  = 4'd1;
   localparam mlen_t MLEN4  = 4'd3;
   localparam mlen_t MLEN8  = 4'd7;
   localparam mlen_t MLEN16 = 4'd15;

   typedef struct packed {
      logic    valid;
      logic    is_write;
      msize_t  size;
      addr_t   addr;
      mlen_t   len;
      strobe_t strobe;
      word_t   data;
   } cbus_req_t;

   typedef struct packed {
      logic  ready;
      logic  last;
      word_t data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_rr_picker.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin from rr_ptr.
module rr_picker #(
   parameter int unsigned NUM_CHANNELS = 4
) (
   input  logic [NUM_CHANNELS-1:0]         valid,
   input  logic [$clog2(NUM_CHANNELS)-1:0] rr_ptr,
   input  logic [NUM_CHANNELS-1:0]         exclude,
   input  logic                            rr_mode,
   output logic                            found,
   output logic [$clog2(NUM_CHANNELS)-1:0] index
);

   localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);

   logic [NUM_CHANNELS-1:0] cand;
   int unsigned             pos;

   assign cand = valid & ~exclude;

   // Scan candidates starting at rr_ptr (RR) or index 0 (fixed); first hit wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = 0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         pos = rr_mode ? ((32'(rr_ptr) + k) % NUM_CHANNELS) : k;
         if (!found && cand[pos[IDX_W-1:0]]) begin
            found = 1'b1;
            index = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// N-channel cache-bus arbiter: grants one requester a whole burst onto the memory port.
module cbus_arbiter_rr
   import cbus_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter bit          RR_MODE      = 1'b1,
   parameter bit          BACK_TO_BACK = 1'b0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  cbus_req_t                       ireqs  [NUM_CHANNELS],
   output cbus_resp_t                      iresps [NUM_CHANNELS],
   output cbus_req_t                       oreq,
   input  cbus_resp_t                      oresp,
   output logic                            grant_valid,
   output logic [$clog2(NUM_CHANNELS)-1:0] grant_idx,
   output logic                            proto_err
);

   localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);

   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic {IDLE, BUSY} arb_state_t;

   arb_state_t state_q, state_d;
   idx_t       grant_q, grant_d;
   idx_t       rr_ptr_q, rr_ptr_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;
   logic       proto_err_q, proto_err_d;
   cbus_req_t  hold_q, hold_d;

   logic [NUM_CHANNELS-1:0] req_valid;
   logic [NUM_CHANNELS-1:0] excl;
   idx_t                    next_ptr;
   idx_t                    pick_ptr;
   logic                    pick_found;
   idx_t                    pick_idx;
   logic                    burst_end;

   assign burst_end = (state_q == BUSY) && oresp.ready && oresp.last;
   assign next_ptr  = (grant_q == idx_t'(NUM_CHANNELS - 1)) ? '0 : grant_q + idx_t'(1);
   // At burst end the decision already uses the pointer the burst is about to leave behind.
   assign pick_ptr  = (state_q == BUSY) ? next_ptr : rr_ptr_q;

   // Collect request valids; the current owner is excluded from a back-to-back decision.
   always_comb begin
      req_valid = '0;
      excl      = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         req_valid[i] = ireqs[i].valid;
      end
      if (state_q == BUSY) begin
         excl[grant_q] = 1'b1;
      end
   end

   rr_picker #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_picker (
      .valid   (req_valid),
      .rr_ptr  (pick_ptr),
      .exclude (excl),
      .rr_mode (RR_MODE),
      .found   (pick_found),
      .index   (pick_idx)
   );

   // Next-state: arbitration in IDLE, beat counting and burst-end handling in BUSY.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      proto_err_d = 1'b0;
      hold_d      = hold_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d    = BUSY;
               grant_d    = pick_idx;
               hold_d     = ireqs[pick_idx];
               beat_cnt_d = '0;
            end
         end
         BUSY: begin
            if (oresp.ready && beat_cnt_q != 4'd15) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
            end
            if (burst_end) begin
               // beat_cnt holds beats before this one, so beat_cnt+1 != len+1 reduces to this.
               proto_err_d = (beat_cnt_q != hold_q.len);
               if (RR_MODE) begin
                  rr_ptr_d = next_ptr;
               end
               beat_cnt_d = '0;
               if (BACK_TO_BACK && pick_found) begin
                  grant_d = pick_idx;
                  hold_d  = ireqs[pick_idx];
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; an in-flight burst is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         proto_err_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         proto_err_q <= proto_err_d;
         hold_q      <= hold_d;
      end
   end

   // Output mux: latched command, live write data, response routed only to the owner.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         iresps[i] = '0;
      end
      if (state_q == BUSY && !reset) begin
         oreq           = hold_q;
         oreq.valid     = 1'b1;
         oreq.data      = ireqs[grant_q].data;
         oreq.strobe    = ireqs[grant_q].strobe;
         iresps[grant_q] = oresp;
      end
   end

   assign grant_valid = (state_q == BUSY);
   assign grant_idx   = grant_q;
   assign proto_err   = proto_err_q;

endmodule
